// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the fetch-stage program counter.
package fetch_pc_unit_pkg;

    localparam int unsigned PC_XLEN    = 32;
    localparam int unsigned INSN_BYTES = 4;

    typedef logic [PC_XLEN-1:0] word_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam word_t BOOT_ADDR_DEFAULT   = 32'h0000_0000;
    localparam word_t TRAP_VECTOR_DEFAULT = 32'h0000_0100;

    function automatic logic addr_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_pc_unit_return_address_stack.sv
// Circular return-address stack: push on call, pop on return; a push when full overwrites the oldest entry.
module return_address_stack #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [XLEN-1:0]  entry_r [DEPTH];
    logic [PTR_W-1:0] top_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             pop_s;

    assign empty = (count_r == {(PTR_W+1){1'b0}});
    assign top   = entry_r[top_ptr_r];
    assign pop_s = pop & ~empty;

    // Stack pointer, occupancy and entry storage; pop+push rewrites the top in place.
    always_ff @(posedge clock) begin
        if (reset) begin
            top_ptr_r <= {PTR_W{1'b0}};
            count_r   <= {(PTR_W+1){1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_r[i] <= {XLEN{1'b0}};
            end
        end else if (push && pop_s) begin
            entry_r[top_ptr_r] <= push_data;
        end else if (push) begin
            entry_r[top_ptr_r + PTR_W'(1)] <= push_data;
            top_ptr_r <= top_ptr_r + PTR_W'(1);
            if (count_r != (PTR_W+1)'(DEPTH)) begin
                count_r <= count_r + (PTR_W+1)'(1);
            end
        end else if (pop_s) begin
            top_ptr_r <= top_ptr_r - PTR_W'(1);
            count_r   <= count_r - (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC with BOOT/RUN/HALT control, trap/redirect/jump selection and misalignment trapping.
// Optional return-address-stack prediction is enabled by defining FETCH_PC_RAS_EN.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int unsigned      XLEN        = PC_XLEN,
    parameter logic [XLEN-1:0]  BOOT_ADDR   = BOOT_ADDR_DEFAULT,
    parameter logic [XLEN-1:0]  TRAP_VECTOR = TRAP_VECTOR_DEFAULT,
    parameter int unsigned      RAS_DEPTH   = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            fetch_ready,
    input  logic            trap,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_tgt,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_offset,
    input  logic            halt,
    input  logic            resume,
    input  logic            call,
    input  logic            ret,
    output logic [XLEN-1:0] pc,
    output logic            fetch_valid,
    output logic            misaligned,
    output logic            ras_hit
);

    fetch_state_e    state_r, state_next_s;
    logic [XLEN-1:0] pc_r, pc_next_s, jump_tgt_s, ras_top_s;
    logic            fetch_valid_r, misaligned_r, ras_hit_r;
    logic            mis_next_s, hit_next_s;
    logic            accept_s, redirect_en_s, ras_empty_s;

    assign accept_s      = fetch_valid_r & fetch_ready;
    assign redirect_en_s = redirect & (state_r != HALT);
    assign jump_tgt_s    = pc_r + jump_offset;

`ifdef FETCH_PC_RAS_EN
    logic ras_push_s, ras_pop_s;

    // The RAS only moves on accepted fetches that are not overridden by trap or redirect.
    assign ras_push_s = accept_s & ~trap & ~redirect_en_s & call;
    assign ras_pop_s  = accept_s & ~trap & ~redirect_en_s & ~jump & ret & ~ras_empty_s;

    return_address_stack #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (ras_push_s),
        .pop       (ras_pop_s),
        .push_data (pc_r + XLEN'(INSN_BYTES)),
        .top       (ras_top_s),
        .empty     (ras_empty_s)
    );
`else
    localparam int unsigned UNUSED_RAS_DEPTH = RAS_DEPTH;
    logic unused_ras_inputs_s;

    assign ras_empty_s         = 1'b1;
    assign ras_top_s           = {XLEN{1'b0}};
    assign unused_ras_inputs_s = &{1'b0, call, ret};
`endif

    // Next-PC selection by priority: trap, redirect, jump, RAS prediction, sequential, hold.
    always_comb begin
        pc_next_s  = pc_r;
        mis_next_s = 1'b0;
        hit_next_s = 1'b0;
        if (trap) begin
            pc_next_s = TRAP_VECTOR;
        end else if (redirect_en_s) begin
            if (addr_misaligned(redirect_tgt[1:0])) begin
                pc_next_s  = TRAP_VECTOR;
                mis_next_s = 1'b1;
            end else begin
                pc_next_s = redirect_tgt;
            end
        end else if (accept_s && jump) begin
            if (addr_misaligned(jump_tgt_s[1:0])) begin
                pc_next_s  = TRAP_VECTOR;
                mis_next_s = 1'b1;
            end else begin
                pc_next_s = jump_tgt_s;
            end
        end else if (accept_s && ret && !ras_empty_s) begin
            pc_next_s  = ras_top_s;
            hit_next_s = 1'b1;
        end else if (accept_s) begin
            pc_next_s = pc_r + XLEN'(INSN_BYTES);
        end else begin
            pc_next_s = pc_r;
        end
    end

    // Run-control state transitions; trap always lands in RUN.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            BOOT: state_next_s = RUN;
            RUN: begin
                if (trap) begin
                    state_next_s = RUN;
                end else if (halt) begin
                    state_next_s = HALT;
                end else begin
                    state_next_s = RUN;
                end
            end
            HALT: begin
                if (trap || resume) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = HALT;
                end
            end
            default: state_next_s = BOOT;
        endcase
    end

    // State, PC and registered output flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= BOOT;
            pc_r          <= BOOT_ADDR;
            fetch_valid_r <= 1'b0;
            misaligned_r  <= 1'b0;
            ras_hit_r     <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            pc_r          <= pc_next_s;
            fetch_valid_r <= (state_next_s == RUN);
            misaligned_r  <= mis_next_s;
            ras_hit_r     <= hit_next_s;
        end
    end

    assign pc          = pc_r;
    assign fetch_valid = fetch_valid_r;
    assign misaligned  = misaligned_r;
    assign ras_hit     = ras_hit_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: directed scenarios then random traffic against a behavioural model.
module tb_fetch_pc_unit;

    localparam logic [31:0] BOOT = 32'h0000_0000;
    localparam logic [31:0] TRAP = 32'h0000_0100;
    localparam int          RAS_D = 4;
`ifdef FETCH_PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    typedef struct {
        bit          reset, fetch_ready, trap, redirect, jump, halt, resume, call, ret;
        logic [31:0] redirect_tgt, jump_offset;
    } stim_t;

    typedef struct {
        logic [31:0] pc;
        bit          valid, mis, hit;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset, fetch_ready, trap, redirect, jump, halt, resume, call, ret;
    logic [31:0] redirect_tgt, jump_offset, pc;
    logic        fetch_valid, misaligned, ras_hit;

    exp_t exp_q[$];
    int   n_vectors = 0;
    int   n_miscompares = 0;

    // model state: mode 0=booting, 1=running, 2=halted
    logic [31:0] m_pc;
    bit          m_valid, m_mis, m_hit;
    int          m_mode;
    logic [31:0] m_ras[$];

    always #5 clock = ~clock;

    fetch_pc_unit dut (
        .clock(clock), .reset(reset), .fetch_ready(fetch_ready), .trap(trap),
        .redirect(redirect), .redirect_tgt(redirect_tgt), .jump(jump),
        .jump_offset(jump_offset), .halt(halt), .resume(resume), .call(call),
        .ret(ret), .pc(pc), .fetch_valid(fetch_valid), .misaligned(misaligned),
        .ras_hit(ras_hit)
    );

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.fetch_ready = 1'b1;
        return s;
    endfunction

    task automatic model(input stim_t s);
        logic [31:0] old_pc, tgt;
        bit acc, redir;
        if (s.reset) begin
            m_pc = BOOT; m_mode = 0; m_valid = 0; m_mis = 0; m_hit = 0;
            m_ras.delete();
            return;
        end
        old_pc = m_pc;
        acc    = m_valid && s.fetch_ready;
        redir  = s.redirect && (m_mode != 2);
        m_mis  = 0;
        m_hit  = 0;
        if (s.trap) m_pc = TRAP;
        else if (redir || (acc && s.jump)) begin
            tgt = redir ? s.redirect_tgt : old_pc + s.jump_offset;
            if (tgt % 4 != 0) begin m_pc = TRAP; m_mis = 1; end
            else m_pc = tgt;
        end else if (RAS_ON && acc && s.ret && m_ras.size() > 0) begin
            m_pc = m_ras.pop_back();
            m_hit = 1;
        end else if (acc) m_pc = old_pc + 4;
        if (RAS_ON && acc && !s.trap && !redir && s.call) begin
            if (m_ras.size() == RAS_D) void'(m_ras.pop_front());
            m_ras.push_back(old_pc + 4);
        end
        if (s.trap) m_mode = 1;
        else if (m_mode == 0) m_mode = 1;
        else if (m_mode == 1) m_mode = s.halt ? 2 : 1;
        else m_mode = s.resume ? 1 : 2;
        m_valid = (m_mode == 1);
    endtask

    // Apply one cycle of stimulus, predict, and wait until the DUT has taken it.
    task automatic step(input stim_t s);
        exp_t e;
        reset = s.reset; fetch_ready = s.fetch_ready; trap = s.trap;
        redirect = s.redirect; redirect_tgt = s.redirect_tgt; jump = s.jump;
        jump_offset = s.jump_offset; halt = s.halt; resume = s.resume;
        call = s.call; ret = s.ret;
        model(s);
        e.pc = m_pc; e.valid = m_valid; e.mis = m_mis; e.hit = m_hit;
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: pops one expectation per clock and compares every output.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            n_vectors++;
            if (exp_q.size() == 0) begin
                n_miscompares++;
                $display("FAIL scoreboard_empty: no expectation queued at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("pc", pc, e.pc);
                check("fetch_valid", {31'd0, fetch_valid}, {31'd0, e.valid});
                check("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
                check("ras_hit", {31'd0, ras_hit}, {31'd0, e.hit});
            end
        end
    end

    initial begin
        stim_t s;
        int    hits, off;

        // reset, boot bubble, sequential fetch
        s = idle(); s.reset = 1'b1;
        step(s); step(s);
        check("boot_valid", {31'd0, fetch_valid}, 32'd0);
        check("boot_pc", pc, BOOT);
        step(idle());
        check("first_pc", pc, 32'h0);
        check("first_valid", {31'd0, fetch_valid}, 32'd1);
        step(idle()); step(idle()); step(idle());
        check("seq_pc", pc, 32'hC);

        // back-pressure
        s = idle(); s.fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(s);
        check("hold_pc", pc, 32'hC);
        step(idle());
        check("release_pc", pc, 32'h10);

        // jump, then redirect beating jump
        s = idle(); s.jump = 1'b1; s.jump_offset = -32'sd8;
        step(s);
        check("jump_back", pc, 32'h8);
        s = idle(); s.jump = 1'b1; s.jump_offset = 32'h100; s.redirect = 1'b1; s.redirect_tgt = 32'h40;
        step(s);
        check("redirect_over_jump", pc, 32'h40);

        // misaligned redirect, halt, trap out of halt
        s = idle(); s.redirect = 1'b1; s.redirect_tgt = 32'h42;
        step(s);
        check("mis_pc", pc, TRAP);
        check("mis_pulse", {31'd0, misaligned}, 32'd1);
        s = idle(); s.halt = 1'b1;
        step(s);
        s = idle(); s.trap = 1'b1;
        step(s);
        check("trap_halt_pc", pc, TRAP);
        check("trap_halt_valid", {31'd0, fetch_valid}, 32'd1);

        // halt at 0x20 completes its advance, ignores redirects, resumes at 0x24
        s = idle(); s.redirect = 1'b1; s.redirect_tgt = 32'h20;
        step(s);
        s = idle(); s.halt = 1'b1;
        step(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.redirect = (i % 2 == 0); s.redirect_tgt = 32'h200;
            step(s);
        end
        check("halted_pc", pc, 32'h24);
        check("halted_valid", {31'd0, fetch_valid}, 32'd0);
        s = idle(); s.resume = 1'b1;
        step(s);
        step(idle());
        check("resume_pc", pc, 32'h28);

        // trap beats halt; address wraparound
        s = idle(); s.trap = 1'b1; s.halt = 1'b1;
        step(s);
        check("trap_halt_same", {31'd0, fetch_valid}, 32'd1);
        s = idle(); s.redirect = 1'b1; s.redirect_tgt = 32'hFFFF_FFFC;
        step(s);
        step(idle());
        check("wrap_pc", pc, 32'h0);

`ifdef FETCH_PC_RAS_EN
        s = idle(); s.reset = 1'b1;
        step(s);
        step(idle());
        s = idle(); s.redirect = 1'b1; s.redirect_tgt = 32'h10;
        step(s);
        s = idle(); s.call = 1'b1;
        step(s);
        s = idle(); s.redirect = 1'b1; s.redirect_tgt = 32'h80;
        step(s);
        s = idle(); s.ret = 1'b1;
        step(s);
        check("ras_ret_pc", pc, 32'h14);
        check("ras_ret_hit", {31'd0, ras_hit}, 32'd1);
        s = idle(); s.call = 1'b1;
        for (int i = 0; i < 5; i++) step(s);
        hits = 0;
        s = idle(); s.ret = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(s);
            hits += int'(ras_hit);
        end
        check("ras_overflow_hits", 32'(hits), 32'd4);
        check("ras_fallback_pc", pc, 32'h20);
`endif

        // random traffic
        s = idle(); s.reset = 1'b1;
        step(s);
        for (int n = 0; n < 3000; n++) begin
            s = '{default: 0};
            s.reset       = ($urandom_range(0, 299) == 0);
            s.fetch_ready = ($urandom_range(0, 3) != 0);
            s.trap        = ($urandom_range(0, 39) == 0);
            s.redirect    = ($urandom_range(0, 9) == 0);
            s.redirect_tgt = ($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom) & 32'hFFFF_FFFC);
            s.jump        = ($urandom_range(0, 7) == 0);
            off           = int'($urandom_range(0, 64)) - 32;
            s.jump_offset = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'(off * 4);
            s.halt        = ($urandom_range(0, 24) == 0);
            s.resume      = ($urandom_range(0, 3) == 0);
            s.call        = ($urandom_range(0, 5) == 0);
            s.ret         = ($urandom_range(0, 5) == 0);
            step(s);
        end

        if (exp_q.size() != 0) begin
            n_miscompares++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
